// File: rtl/vend_credit_fsm.sv
// rtl/vend_credit_fsm.sv - coin-credit vending controller with held vend request and pulsed change return
module vend_credit_fsm #(
  parameter int CREDIT_W = 8,
  parameter int PRICE    = 15,
  parameter int COIN_LO  = 5,
  parameter int COIN_HI  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coins,
  input  logic                cancel,
  input  logic                dispense_ack,
  output logic                coffee,
  output logic                change_out,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_REFUND  = 3'd4
  } state_t;

  localparam logic [CREDIT_W-1:0] P_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] P_LO    = CREDIT_W'(COIN_LO);
  localparam logic [CREDIT_W-1:0] P_HI    = CREDIT_W'(COIN_HI);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                reject_q, reject_d;

  logic                coin_valid;
  logic                coin_any;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] change_dec;

  assign coin_valid = (coins == 2'b01) || (coins == 2'b10);
  assign coin_any   = (coins != 2'b00);
  assign coin_val   = (coins == 2'b01) ? P_HI : ((coins == 2'b10) ? P_LO : '0);
  assign sum        = credit_q + coin_val;
  assign change_dec = change_q - P_LO;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        // Cancel outranks a coin arriving in the same cycle; that coin is bounced.
        if (state_q == S_COLLECT && cancel && credit_q != '0) begin
          state_d  = S_REFUND;
          change_d = credit_q;
          credit_d = '0;
          reject_d = coin_any;
        end else if (coin_valid) begin
          if (sum >= P_PRICE) begin
            state_d  = S_VEND;
            change_d = sum - P_PRICE;
            credit_d = '0;
          end else begin
            state_d  = S_COLLECT;
            credit_d = sum;
          end
        end else begin
          reject_d = coin_any;
        end
      end
      S_VEND: begin
        reject_d = coin_any;
        if (dispense_ack) begin
          state_d = (change_q != '0) ? S_CHANGE : S_IDLE;
        end
      end
      S_CHANGE, S_REFUND: begin
        reject_d = coin_any;
        change_d = change_dec;
        if (change_dec == '0) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
        change_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      change_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      reject_q <= reject_d;
    end
  end

  assign coffee      = (state_q == S_VEND);
  assign change_out  = (state_q == S_CHANGE) || (state_q == S_REFUND);
  assign busy        = coffee || change_out;
  assign coin_reject = reject_q;
  assign credit      = credit_q;

endmodule
